// File: rtl/mvm_rr_scheduler.sv
// Round-robin scheduler that shares one MVM engine among NUM_REQ requesters.
// Job flow: IDLE -> ISSUE -> ARM -> RUN -> DONE -> IDLE.
// - ISSUE snapshots the winner's vector and weight and pulses the engine start.
// - ARM ignores i_ismvm for one cycle, so a stale "idle" from the previous job
//   is not mistaken for completion.
// - RUN waits for i_ismvm to fall, or aborts after TIMEOUT busy cycles.
// Handshake: a level i_req is a held request; o_gnt is the acknowledge and
// stays high from ISSUE through the completion cycle. The completion cycle
// carries a one-cycle o_done or o_err pulse. A requester may drop i_req once
// granted; the job still runs to completion.
module mvm_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int NUM_BIT = 8,
  parameter int DIM     = 4,
  parameter int TIMEOUT = 1023,
  localparam int PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW     = $clog2(TIMEOUT + 1)
) (
  input  logic                                   i_clk_mvmSch,
  input  logic                                   i_rst_mvmSch,
  input  logic [NUM_REQ-1:0]                     i_req,
  input  logic [NUM_REQ-1:0][DIM-1:0][NUM_BIT-1:0] i_x_req,
  input  logic [NUM_REQ-1:0][NUM_BIT-1:0]        i_wt_req,
  output logic [NUM_REQ-1:0]                     o_gnt,
  output logic [NUM_REQ-1:0]                     o_done,
  output logic [NUM_REQ-1:0]                     o_err,
  output logic [DIM-1:0][NUM_BIT-1:0]            o_y_vector,
  output logic                                   o_busy,
  output logic                                   o_start_mvm,
  output logic [DIM-1:0][NUM_BIT-1:0]            o_x_mvm,
  output logic [NUM_BIT-1:0]                     o_wt_mvm,
  output logic                                   o_sign,
  input  logic                                   i_ismvm,
  input  logic [DIM-1:0][NUM_BIT-1:0]            i_wx_result,
  output logic [2:0]                             state_dbg,
  output logic [PW-1:0]                          rr_ptr_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] nxt_ptr;
  logic [CW-1:0] cnt;

  logic          sel_valid;
  logic [PW-1:0] sel_idx;
  logic [PW:0]   cand;

  assign o_busy     = (state != S_IDLE);
  assign o_sign     = o_wt_mvm[NUM_BIT-1];
  assign state_dbg  = state;
  assign rr_ptr_dbg = rr_ptr;
  assign nxt_ptr    = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Pick the first requester at or after rr_ptr (wrapping). The scan runs from
  // the farthest offset down to offset 0, so the nearest requester is written
  // last and wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_REQ)) cand = cand - (PW+1)'(NUM_REQ);
      if (i_req[cand[PW-1:0]]) begin
        sel_valid = 1'b1;
        sel_idx   = cand[PW-1:0];
      end
    end
  end

  // Job sequencer: state, grant, snapshot, timeout counter and result capture.
  always_ff @(posedge i_clk_mvmSch) begin
    if (i_rst_mvmSch) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      gnt_idx     <= '0;
      cnt         <= '0;
      o_gnt       <= '0;
      o_done      <= '0;
      o_err       <= '0;
      o_start_mvm <= 1'b0;
      o_x_mvm     <= '0;
      o_wt_mvm    <= '0;
      o_y_vector  <= '0;
    end else begin
      o_start_mvm <= 1'b0;
      o_done      <= '0;
      o_err       <= '0;
      case (state)
        S_IDLE: begin
          if (sel_valid) begin
            state       <= S_ISSUE;
            gnt_idx     <= sel_idx;
            o_gnt       <= NUM_REQ'(1) << sel_idx;
            o_x_mvm     <= i_x_req[sel_idx];
            o_wt_mvm    <= i_wt_req[sel_idx];
            o_start_mvm <= 1'b1;
          end else begin
            // A grant left over from a timeout drops here.
            o_gnt <= '0;
          end
        end
        S_ISSUE: state <= S_ARM;
        S_ARM: begin
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          if (!i_ismvm) begin
            // Capture while the engine reports finished, so the result is
            // already visible alongside o_done.
            state      <= S_DONE;
            o_done     <= o_gnt;
            o_y_vector <= i_wx_result;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // Abort: grant is held for the error cycle, result is kept.
            state  <= S_IDLE;
            o_err  <= o_gnt;
            rr_ptr <= nxt_ptr;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_gnt  <= '0;
          rr_ptr <= nxt_ptr;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_rr_scheduler.sv
// Bench for mvm_rr_scheduler: directed jobs, a per-cycle scoreboard and an engine stub.
module tb_mvm_rr_scheduler;
  localparam int NR = 4;
  localparam int NB = 8;
  localparam int DM = 4;
  localparam int TO = 8;

  typedef logic [DM-1:0][NB-1:0] vec_t;
  typedef struct {
    int          idx;
    vec_t        x;
    logic [NB-1:0] wt;
    vec_t        y;
    bit          a;   // i_ismvm level during ARM
    int          k;   // busy cycles after ARM
  } job_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_seen;
  logic [NR-1:0] req = '0;
  logic [NR-1:0][DM-1:0][NB-1:0] x_req;
  logic [NR-1:0][NB-1:0] wt_req;
  logic [NR-1:0] o_gnt, o_done, o_err;
  vec_t o_y_vector, o_x_mvm, i_wx_result;
  logic o_busy, o_start_mvm, o_sign, i_ismvm;
  logic [NB-1:0] o_wt_mvm;
  logic [2:0] state_dbg;
  logic [1:0] rr_ptr_dbg;

  mvm_rr_scheduler #(.NUM_REQ(NR), .NUM_BIT(NB), .DIM(DM), .TIMEOUT(TO)) dut (
    .i_clk_mvmSch(clk), .i_rst_mvmSch(rst), .i_req(req), .i_x_req(x_req),
    .i_wt_req(wt_req), .o_gnt(o_gnt), .o_done(o_done), .o_err(o_err),
    .o_y_vector(o_y_vector), .o_busy(o_busy), .o_start_mvm(o_start_mvm),
    .o_x_mvm(o_x_mvm), .o_wt_mvm(o_wt_mvm), .o_sign(o_sign), .i_ismvm(i_ismvm),
    .i_wx_result(i_wx_result), .state_dbg(state_dbg), .rr_ptr_dbg(rr_ptr_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) rst_seen <= rst;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  job_t exp_q[$];
  job_t eng_q[$];
  logic [NR-1:0] grant_log[$];
  job_t cur;
  bit cur_valid = 0;
  int cur_start = 0;
  vec_t model_y = '0;
  int m_ptr = 0;
  int start_cnt = 0, done_cnt = 0, err_cnt = 0;
  int last_lat = 0, last_fin_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin reference: first requester at or after p, wrapping.
  function automatic int rr_pick(input logic [NR-1:0] m, input int p);
    for (int k = 0; k < NR; k++)
      if (m[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  // Plan n jobs for a held mask; the serviced index becomes lowest priority.
  task automatic plan(input logic [NR-1:0] m, input int n, input bit a, input int k, input vec_t y);
    job_t j;
    for (int i = 0; i < n; i++) begin
      j.idx = rr_pick(m, m_ptr);
      j.x = x_req[j.idx];
      j.wt = wt_req[j.idx];
      j.y = y;
      j.a = a;
      j.k = k;
      exp_q.push_back(j);
      eng_q.push_back(j);
      m_ptr = (j.idx + 1) % NR;
    end
  endtask

  // ---------------- compare process ----------------
  initial begin : compare
    int rel, dur;
    bit fin, tmo, ok;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_seen) begin
        chk("rst_gnt", o_gnt, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_start", o_start_mvm, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_x", o_x_mvm, 0);
        chk("rst_wt", o_wt_mvm, 0);
        chk("rst_y", o_y_vector, 0);
        chk("rst_state", state_dbg, 0);
        chk("rst_ptr", rr_ptr_dbg, 0);
        exp_q.delete();
        eng_q.delete();
        cur_valid = 0;
        model_y = '0;
      end else begin
        if (o_start_mvm) begin
          ok = (exp_q.size() != 0) && !cur_valid;
          chk("start_expected", {63'b0, ok}, 1);
          if (ok) begin
            cur = exp_q.pop_front();
            cur_valid = 1;
            cur_start = cyc;
            start_cnt++;
            grant_log.push_back(o_gnt);
          end
        end
        if (cur_valid) begin
          rel = cyc - cur_start;
          tmo = (cur.k >= TO);
          dur = tmo ? (2 + TO) : (3 + cur.k);
          fin = (rel == dur);
          chk("gnt", o_gnt, onehot(cur.idx));
          chk("x_snap", o_x_mvm, cur.x);
          chk("wt_snap", o_wt_mvm, cur.wt);
          chk("start_pulse", o_start_mvm, rel == 0);
          chk("busy", o_busy, !(fin && tmo));
          chk("done", o_done, (fin && !tmo) ? onehot(cur.idx) : '0);
          chk("err", o_err, (fin && tmo) ? onehot(cur.idx) : '0);
          if (o_done != 0) done_cnt++;
          if (o_err != 0) err_cnt++;
          if (fin) begin
            if (!tmo) model_y = cur.y;
            cur_valid = 0;
            last_lat = rel;
            last_fin_cyc = cyc;
          end
        end else if (!o_start_mvm) begin
          chk("idle_gnt", o_gnt, 0);
          chk("idle_busy", o_busy, 0);
          chk("idle_done", o_done, 0);
          chk("idle_err", o_err, 0);
        end
        chk("y_vector", o_y_vector, model_y);
        chk("sign", o_sign, o_wt_mvm[NB-1]);
      end
    end
  end

  // ---------------- engine stub ----------------
  initial begin : engine
    job_t p;
    i_ismvm = 1'b0;
    i_wx_result = '0;
    forever begin
      @(negedge clk);
      if (o_start_mvm && eng_q.size() != 0) begin
        p = eng_q.pop_front();
        i_wx_result = p.y;
        i_ismvm = p.a;
        @(negedge clk);
        i_ismvm = p.a;
        repeat (p.k) begin
          @(negedge clk);
          i_ismvm = 1'b1;
        end
        @(negedge clk);
        i_ismvm = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_starts(input int target, input int budget);
    int b;
    b = 0;
    while (start_cnt < target && b < budget) begin
      @(negedge clk);
      #1;
      b++;
    end
    chk("wait_start_bound", {63'b0, start_cnt >= target}, 1);
  endtask

  task automatic wait_quiet(input int budget);
    int b;
    b = 0;
    while ((exp_q.size() != 0 || cur_valid) && b < budget) begin
      @(negedge clk);
      #1;
      b++;
    end
    chk("wait_quiet_bound", {63'b0, exp_q.size() == 0 && !cur_valid}, 1);
    idle(3);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int s0, d0, e0, req_cyc;
    for (int i = 0; i < NR; i++) begin
      x_req[i] = {8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), 8'(8'h40 + i)};
      wt_req[i] = 8'(8'h11 * (i + 1));
    end
    wt_req[2] = 8'h85;
    wt_req[3] = 8'hC3;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(6);
    chk("idle_state", state_dbg, 0);

    // All four requesting; engine busy 2 cycles per job.
    grant_log.delete();
    plan(4'b1111, 5, 1'b1, 1, 32'hA0A1A2A3);
    s0 = start_cnt;
    req = 4'b1111;
    wait_starts(s0 + 5, 200);
    req = 4'b0000;
    wait_quiet(100);
    chk("rot_len", grant_log.size(), 5);
    chk("rot_g0", grant_log[0], 4'b0001);
    chk("rot_g1", grant_log[1], 4'b0010);
    chk("rot_g2", grant_log[2], 4'b0100);
    chk("rot_g3", grant_log[3], 4'b1000);
    chk("rot_g4", grant_log[4], 4'b0001);

    // Single requester 0, engine busy 3 cycles, result {1,2,3,4}.
    s0 = start_cnt; d0 = done_cnt;
    plan(4'b0001, 1, 1'b1, 2, {8'd1, 8'd2, 8'd3, 8'd4});
    req = 4'b0001;
    wait_starts(s0 + 1, 50);
    req = 4'b0000;
    wait_quiet(50);
    chk("single_starts", start_cnt - s0, 1);
    chk("single_dones", done_cnt - d0, 1);
    chk("single_y", o_y_vector, 32'h01020304);
    chk("single_ptr", rr_ptr_dbg, 1);
    chk("single_lat", last_lat, 5);

    // Minimum latency: engine never busy.
    plan(4'b0010, 1, 1'b0, 0, 32'h55667788);
    req_cyc = cyc;
    req = 4'b0010;
    wait_starts(start_cnt + 1, 50);
    req = 4'b0000;
    wait_quiet(50);
    chk("min_latency", last_fin_cyc - req_cyc, 4);

    // Snapshot: requester 2 changes its inputs and drops request while running.
    plan(4'b0100, 1, 1'b1, 3, 32'h0F0E0D0C);
    req = 4'b0100;
    wait_starts(start_cnt + 1, 50);
    req = 4'b0000;
    idle(2);
    wt_req[2] = 8'h05;
    x_req[2] = 32'hDEADBEEF;
    wait_quiet(50);
    chk("snap_wt", o_wt_mvm, 8'h85);
    chk("snap_sign", o_sign, 1);
    chk("snap_y", o_y_vector, 32'h0F0E0D0C);

    // Timeout on requester 3, then requester 0 is served.
    grant_log.delete();
    e0 = err_cnt;
    plan(4'b1001, 1, 1'b1, TO, 32'hFFFFFFFF);
    plan(4'b1001, 1, 1'b1, 1, 32'h0A0B0C0D);
    req = 4'b1001;
    wait_starts(start_cnt + 1, 50);
    wait_quiet_first: begin
      int b;
      b = 0;
      while (err_cnt == e0 && b < 40) begin
        @(negedge clk);
        #1;
        b++;
      end
    end
    chk("to_y_kept", o_y_vector, 32'h0F0E0D0C);
    chk("to_lat", last_lat, 10);
    wait_starts(start_cnt + 1, 50);
    req = 4'b0000;
    wait_quiet(50);
    chk("to_errs", err_cnt - e0, 1);
    chk("to_g0", grant_log[0], 4'b1000);
    chk("to_g1", grant_log[1], 4'b0001);

    // Stale busy: engine idle during ARM, busy afterwards.
    plan(4'b0010, 1, 1'b0, 3, 32'h12345678);
    req = 4'b0010;
    wait_starts(start_cnt + 1, 50);
    req = 4'b0000;
    wait_quiet(50);
    chk("stale_lat", last_lat, 6);

    // Requests arriving while busy wait their turn.
    grant_log.delete();
    plan(4'b0001, 1, 1'b1, 2, 32'h01010101);
    plan(4'b1100, 2, 1'b1, 1, 32'h02020202);
    req = 4'b0001;
    wait_starts(start_cnt + 1, 50);
    req = 4'b1100;
    wait_starts(start_cnt + 2, 100);
    req = 4'b0000;
    wait_quiet(50);
    chk("wait_g1", grant_log[1], 4'b0100);
    chk("wait_g2", grant_log[2], 4'b1000);

    // Reset in the middle of RUN abandons the job.
    d0 = done_cnt; e0 = err_cnt;
    plan(4'b0100, 1, 1'b1, 6, 32'h77777777);
    req = 4'b0100;
    wait_starts(start_cnt + 1, 50);
    req = 4'b0000;
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    m_ptr = 0;
    idle(10);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_no_err", err_cnt - e0, 0);
    grant_log.delete();
    plan(4'b1010, 1, 1'b1, 1, 32'h31323334);
    req = 4'b1010;
    wait_starts(start_cnt + 1, 50);
    req = 4'b0000;
    wait_quiet(50);
    chk("post_rst_gnt", grant_log[0], 4'b0010);
    chk("post_rst_y", o_y_vector, 32'h31323334);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
